gate1_bist: RTL and testbench

//   Synchronous on-chip stimulus generator and response checker for the gate1 two-input gate block.

---
 rtl/gate1_bist.sv | 122 ++++++++++++
 tb/tb_gate1_bist.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gate1_bist.sv
// Stimulus generator and response checker for the gate1 two-input gate block.
// Walks all four (a,b) vectors, compares eight gate outputs and reports the first failure.
module gate1_bist #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   input  logic [7:0]       dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       fail_vec,
   output logic [7:0]       fail_mask
);

   // Zero settle would skip the hold entirely, so it is promoted to one cycle.
   localparam int unsigned     S       = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam int unsigned     CntW    = (S > 1) ? $clog2(S) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(S - 1);
   localparam logic [ERR_W-1:0] ErrMax = '1;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StCheck,
      StDone
   } state_e;

   state_e          state_q;
   logic [1:0]      vec_q;
   logic [CntW-1:0] cnt_q;
   logic [7:0]      exp_out;
   logic [7:0]      mask;
   logic            va;
   logic            vb;

   always_comb begin
      va      = vec_q[1];
      vb      = vec_q[0];
      exp_out = {va & vb, va | vb, ~(va & vb), ~(va | vb), va ^ vb, ~(va ^ vb), ~va, ~vb};
      mask    = dut_out ^ exp_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         vec_q     <= 2'd0;
         cnt_q     <= '0;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= 2'd0;
         fail_mask <= 8'd0;
      end else if (start && (state_q == StIdle || state_q == StDone)) begin
         state_q   <= StDrive;
         vec_q     <= 2'd0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= 2'd0;
         fail_mask <= 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               busy <= 1'b0;
            end
            StDrive: begin
               busy    <= 1'b1;
               a       <= vec_q[1];
               b       <= vec_q[0];
               cnt_q   <= '0;
               state_q <= StSettle;
            end
            StSettle: begin
               busy <= 1'b1;
               if (cnt_q == CntLast) begin
                  state_q <= StCheck;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StCheck: begin
               busy <= 1'b1;
               if (mask != 8'd0) begin
                  if (err_count != ErrMax) begin
                     err_count <= err_count + 1'b1;
                  end
                  if (err_count == '0) begin
                     fail_vec  <= vec_q;
                     fail_mask <= mask;
                  end
               end
               if (vec_q == 2'd3) begin
                  state_q <= StDone;
               end else begin
                  vec_q   <= vec_q + 2'd1;
                  state_q <= StDrive;
               end
            end
            StDone: begin
               // Results surface one edge after the final check so pass sees its outcome.
               busy <= 1'b0;
               done <= 1'b1;
               pass <= (err_count == '0);
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate1_bist.sv
// Directed bench for gate1_bist: golden gate1 model with injectable faults, two DUT widths.
module tb_gate1_bist;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   int         fault;

   logic       a, b, busy, done, pass;
   logic [3:0] err_count;
   logic [1:0] fail_vec;
   logic [7:0] fail_mask, dut_out;

   logic       a2, b2, busy2, done2, pass2;
   logic [1:0] err_count2;
   logic [1:0] fail_vec2;
   logic [7:0] fail_mask2, dut_out2;

   int n_tests = 0;
   int n_fail  = 0;

   int done_edge, busy_cycles, ab_errs;

   always #5 clk = ~clk;

   // 0: good gate, 1: xor output stuck at 0, 2: every output inverted
   function automatic logic [7:0] gate1(input logic ga, input logic gb, input int mode);
      logic [7:0] y;
      y = {ga & gb, ga | gb, ~(ga & gb), ~(ga | gb), ga ^ gb, ~(ga ^ gb), ~ga, ~gb};
      if (mode == 1) y[3] = 1'b0;
      if (mode == 2) y = ~y;
      return y;
   endfunction

   assign dut_out  = gate1(a, b, fault);
   assign dut_out2 = gate1(a2, b2, fault);

   gate1_bist dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec),
      .fail_mask (fail_mask)
   );

   gate1_bist #(.SETTLE_CYCLES(2), .ERR_W(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a2),
      .b         (b2),
      .dut_out   (dut_out2),
      .busy      (busy2),
      .done      (done2),
      .pass      (pass2),
      .err_count (err_count2),
      .fail_vec  (fail_vec2),
      .fail_mask (fail_mask2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start, then watch up to 40 edges; optional extra start / rst at edge k after accept.
   task automatic run(input int extra_at, input int rst_at);
      done_edge   = 0;
      busy_cycles = 0;
      ab_errs     = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check("accept_clears_err", 32'(err_count), 32'd0);
      check("accept_clears_done", 32'(done), 32'd0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = (k == extra_at);
         rst   = (k == rst_at);
         @(posedge clk);
         #1;
         if (k == rst_at) break;
         if (busy) busy_cycles++;
         if (k <= 16 && {a, b} != 2'((k - 1) / 4)) ab_errs++;
         if (done) begin
            done_edge = k;
            break;
         end
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic check_timing(input string tag);
      check({tag, "_done_edge"}, 32'(done_edge), 32'd17);
      check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
      check({tag, "_ab_trace_errs"}, 32'(ab_errs), 32'd0);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
      check({tag, "_ab_hold"}, 32'({a, b}), 32'd3);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      fault = 0;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_ab", 32'({a, b}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_fail_vec", 32'(fail_vec), 32'd0);
      check("rst_fail_mask", 32'(fail_mask), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Good DUT
      run(0, 0);
      check_timing("good");
      check("good_pass", 32'(pass), 32'd1);
      check("good_err", 32'(err_count), 32'd0);
      check("good_mask", 32'(fail_mask), 32'd0);

      // xor stuck at 0: fails on 01 and 10
      fault = 1;
      run(0, 0);
      check_timing("xor");
      check("xor_pass", 32'(pass), 32'd0);
      check("xor_err", 32'(err_count), 32'd2);
      check("xor_fail_vec", 32'(fail_vec), 32'd1);
      check("xor_fail_mask", 32'(fail_mask), 32'h08);
      check("xor_done_level", 32'(done), 32'd1);

      // Restart from DONE with a good DUT
      fault = 0;
      run(0, 0);
      check_timing("rerun");
      check("rerun_pass", 32'(pass), 32'd1);
      check("rerun_err", 32'(err_count), 32'd0);
      check("rerun_fail_vec", 32'(fail_vec), 32'd0);

      // All outputs inverted: every vector fails, narrow counter saturates
      fault = 2;
      run(0, 0);
      check("inv_err_w2", 32'(err_count2), 32'd3);
      check("inv_fail_vec_w2", 32'(fail_vec2), 32'd0);
      check("inv_fail_mask_w2", 32'(fail_mask2), 32'hFF);
      check("inv_pass_w2", 32'(pass2), 32'd0);
      check("inv_done_w2", 32'(done2), 32'd1);
      check("inv_err_w4", 32'(err_count), 32'd4);
      check("inv_fail_mask_w4", 32'(fail_mask), 32'hFF);

      // Start while busy is ignored
      fault = 0;
      run(5, 0);
      check_timing("busy_start");
      check("busy_start_pass", 32'(pass), 32'd1);

      // Reset mid-run aborts
      run(0, 7);
      check("abort_no_done", 32'(done_edge), 32'd0);
      check("abort_outputs",
            32'({a, b, busy, done, pass, err_count, fail_vec, fail_mask}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_stays_idle", 32'({busy, done}), 32'd0);

      run(0, 0);
      check_timing("after_abort");
      check("after_abort_pass", 32'(pass), 32'd1);
      check("after_abort_err", 32'(err_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
